// File: rtl/sevenseg_595_scan.sv
// Multiplexed 7-segment scanner for chained 74HC595 Pmods (digit-select byte, then segment byte).
// Double-buffered display data is swapped in only at frame boundaries so a frame never tears.
module sevenseg_595_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 6250,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [8*NUM_DIGITS-1:0] raw_seg,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    raw_mode,
  input  logic                    load,
  output logic                    updated,
  output logic                    sclk,
  output logic                    rclk,
  output logic                    srclr_n,
  output logic                    sdata,
  output logic [2:0]              digit_idx
);

  localparam int             CNT_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]     LAST_DIGIT = 3'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [8*NUM_DIGITS-1:0] raw_seg;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    raw_mode;
  } disp_t;

  // Power-up contents: every digit blanked so the display stays dark until a load.
  localparam disp_t RESET_DISP = '{value: '0, raw_seg: '0, dp: '0, blank: '1, raw_mode: 1'b0};

  typedef enum logic [1:0] {S_CLEAR, S_SHIFT, S_LATCH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             phase;
  logic [3:0]       bit_idx;
  logic [15:0]      word_q;
  logic [15:0]      word_now;
  logic [7:0]       seg_now;
  logic [7:0]       dig_now;
  logic [3:0]       nib;
  logic [7:0]       raw_byte;
  logic             dp_bit;
  logic             blank_bit;
  disp_t            in_data;
  disp_t            pending_data;
  disp_t            shadow;
  logic             pending;

  assign tick    = (cnt == CNT_MAX);
  assign in_data = '{value: value, raw_seg: raw_seg, dp: dp, blank: blank, raw_mode: raw_mode};

  function automatic logic [7:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 8'hFC;
      4'h1:    font = 8'h60;
      4'h2:    font = 8'hDA;
      4'h3:    font = 8'hF2;
      4'h4:    font = 8'h66;
      4'h5:    font = 8'hB6;
      4'h6:    font = 8'hBE;
      4'h7:    font = 8'hE0;
      4'h8:    font = 8'hFE;
      4'h9:    font = 8'hF6;
      4'hA:    font = 8'hEE;
      4'hB:    font = 8'h3E;
      4'hC:    font = 8'h9C;
      4'hD:    font = 8'h7A;
      4'hE:    font = 8'h9E;
      default: font = 8'h8E;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves one unassigned (no latch).
    nib       = '0;
    raw_byte  = '0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == 3'(i)) begin
        nib       = shadow.value[4*i +: 4];
        raw_byte  = shadow.raw_seg[8*i +: 8];
        dp_bit    = shadow.dp[i];
        blank_bit = shadow.blank[i];
      end
    end
    if (blank_bit)            seg_now = 8'h00;
    else if (shadow.raw_mode) seg_now = raw_byte;
    else                      seg_now = font(nib) | {7'b0, dp_bit};
    dig_now = 8'b1 << digit_idx;
    if (DIG_ACTIVE_LOW) dig_now = ~dig_now;
    word_now = {dig_now, seg_now};
  end

  // NOTE: pending_data has no reset; it is only ever consumed while pending is set.
  always_ff @(posedge clk) begin
    if (load) pending_data <= in_data;
  end

  // NOTE: all state uses non-blocking assignments so later statements see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      state     <= S_CLEAR;
      phase     <= 1'b0;
      bit_idx   <= 4'd15;
      word_q    <= '0;
      sclk      <= 1'b0;
      rclk      <= 1'b0;
      sdata     <= 1'b0;
      srclr_n   <= 1'b0;
      updated   <= 1'b0;
      digit_idx <= '0;
      shadow    <= RESET_DISP;
      pending   <= 1'b0;
    end else begin
      updated <= 1'b0;
      cnt     <= tick ? '0 : cnt + 1'b1;
      if (load) pending <= 1'b1;
      if (tick) begin
        unique case (state)
          S_CLEAR: begin
            phase <= ~phase;
            if (phase) begin
              srclr_n   <= 1'b1;
              state     <= S_SHIFT;
              bit_idx   <= 4'd15;
              digit_idx <= '0;
              phase     <= 1'b0;
            end
          end
          S_SHIFT: begin
            if (!phase) begin
              sclk  <= 1'b0;
              phase <= 1'b1;
              // The slot's word is frozen on its first bit; later bits replay the held copy.
              if (bit_idx == 4'd15) begin
                word_q <= word_now;
                sdata  <= word_now[15];
              end else begin
                sdata  <= word_q[bit_idx];
              end
            end else begin
              sclk  <= 1'b1;
              phase <= 1'b0;
              if (bit_idx == 4'd0) state   <= S_LATCH;
              else                 bit_idx <= bit_idx - 4'd1;
            end
          end
          S_LATCH: begin
            if (!phase) begin
              sclk  <= 1'b0;
              rclk  <= 1'b1;
              phase <= 1'b1;
            end else begin
              rclk    <= 1'b0;
              phase   <= 1'b0;
              bit_idx <= 4'd15;
              state   <= S_SHIFT;
              if (digit_idx == LAST_DIGIT) begin
                digit_idx <= '0;
                // Frame boundary: a load arriving on this very cycle wins over older pending data.
                if (pending || load) begin
                  shadow  <= load ? in_data : pending_data;
                  updated <= 1'b1;
                  pending <= 1'b0;
                end
              end else begin
                digit_idx <= digit_idx + 3'd1;
              end
            end
          end
          default: state <= S_CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_595_scan.sv
// Directed bench: behavioural 74HC595 models log every latched word of three scanner configurations.
module tb_sevenseg_595_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // 4-digit, active-low select: main device under test
  logic [15:0] value4;
  logic [31:0] raw4;
  logic [3:0]  dp4, blank4;
  logic        rmode4, load4;
  logic        upd4, sclk4, rclk4, srclr4, sdata4;
  logic [2:0]  didx4;

  // 8-digit active-low and 3-digit active-high: select-byte sweep
  logic        upd8, sclk8, rclk8, srclr8, sdata8;
  logic [2:0]  didx8;
  logic        upd3, sclk3, rclk3, srclr3, sdata3;
  logic [2:0]  didx3;

  sevenseg_595_scan #(.NUM_DIGITS(4), .CLK_DIV(2), .DIG_ACTIVE_LOW(1'b1)) u4 (
    .clk(clk), .rst(rst), .value(value4), .raw_seg(raw4), .dp(dp4), .blank(blank4),
    .raw_mode(rmode4), .load(load4), .updated(upd4), .sclk(sclk4), .rclk(rclk4),
    .srclr_n(srclr4), .sdata(sdata4), .digit_idx(didx4)
  );

  sevenseg_595_scan #(.NUM_DIGITS(8), .CLK_DIV(2), .DIG_ACTIVE_LOW(1'b1)) u8 (
    .clk(clk), .rst(rst), .value(32'h0), .raw_seg(64'h0), .dp(8'h0), .blank(8'h0),
    .raw_mode(1'b0), .load(1'b0), .updated(upd8), .sclk(sclk8), .rclk(rclk8),
    .srclr_n(srclr8), .sdata(sdata8), .digit_idx(didx8)
  );

  sevenseg_595_scan #(.NUM_DIGITS(3), .CLK_DIV(2), .DIG_ACTIVE_LOW(1'b0)) u3 (
    .clk(clk), .rst(rst), .value(12'h0), .raw_seg(24'h0), .dp(3'h0), .blank(3'h0),
    .raw_mode(1'b0), .load(1'b0), .updated(upd3), .sclk(sclk3), .rclk(rclk3),
    .srclr_n(srclr3), .sdata(sdata3), .digit_idx(didx3)
  );

  // Shift/storage register models: words as a real 595 pair would latch them.
  logic [15:0] sh4, sh8, sh3;
  logic [15:0] w4 [0:63];
  logic [15:0] w8 [0:63];
  logic [15:0] w3 [0:63];
  logic [2:0]  di4 [0:63];
  logic [2:0]  di8 [0:63];
  logic [2:0]  di3 [0:63];
  int          nb4 [0:63];
  int sck4 = 0, last4 = 0, n4 = 0, nupd4 = 0;
  int n8 = 0, n3 = 0;

  always @(posedge sclk4) begin
    sh4 = {sh4[14:0], sdata4};
    sck4++;
  end
  always @(posedge rclk4) begin
    if (n4 < 64) begin
      w4[n4]  = sh4;
      di4[n4] = didx4;
      nb4[n4] = sck4 - last4;
    end
    last4 = sck4;
    n4++;
  end
  always @(negedge clk) if (upd4 === 1'b1) nupd4++;

  always @(posedge sclk8) sh8 = {sh8[14:0], sdata8};
  always @(posedge rclk8) begin
    if (n8 < 64) begin
      w8[n8]  = sh8;
      di8[n8] = didx8;
    end
    n8++;
  end

  always @(posedge sclk3) sh3 = {sh3[14:0], sdata3};
  always @(posedge rclk3) begin
    if (n3 < 64) begin
      w3[n3]  = sh3;
      di3[n3] = didx3;
    end
    n3++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_lat4(input int n);
    int k = 0;
    while (n4 < n && k < 6000) begin
      @(negedge clk);
      k++;
    end
    if (n4 < n) begin
      n_cmp++;
      n_fail++;
      $error("FAIL wait_lat4: observed %0d latches, expected %0d", n4, n);
    end
  endtask

  // Expected words packed digit 0 first: {w0, w1, w2, w3}
  task automatic check_frame4(input int base, input logic [63:0] exp_w, input bit chk_bits);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("word4[%0d]", base + d), 32'(w4[base+d]), 32'(exp_w[63-16*d -: 16]));
      check($sformatf("idx4[%0d]", base + d), 32'(di4[base+d]), 32'(d));
      if (chk_bits) check($sformatf("bits4[%0d]", base + d), 32'(nb4[base+d]), 32'd16);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [31:0] r, input logic [3:0] d,
                         input logic [3:0] b, input logic m);
    @(negedge clk);
    value4 = v; raw4 = r; dp4 = d; blank4 = b; rmode4 = m; load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
  endtask

  localparam logic [63:0] BLANK4 = {16'hFE00, 16'hFD00, 16'hFB00, 16'hF700};

  initial begin
    int base;
    int cur;
    int k;
    rst = 1'b1; value4 = '0; raw4 = '0; dp4 = '0; blank4 = '0; rmode4 = 1'b0; load4 = 1'b0;

    // Reset state and the power-up clear sequence
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", 32'(sclk4), 32'd0);
    check("rst_rclk", 32'(rclk4), 32'd0);
    check("rst_srclr", 32'(srclr4), 32'd0);
    check("rst_sdata", 32'(sdata4), 32'd0);
    check("rst_upd", 32'(upd4), 32'd0);
    check("rst_idx", 32'(didx4), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("clear_low_%0d", i), 32'(srclr4), 32'd0);
    end
    @(negedge clk);
    check("clear_done", 32'(srclr4), 32'd1);
    check("clear_sclk", 32'(sclk4), 32'd0);
    check("clear_rclk", 32'(rclk4), 32'd0);

    // Load during frame 1: frame 1 stays dark, frame 2 shows 0x1234
    do_load(16'h1234, 32'h0, 4'h0, 4'h0, 1'b0);
    wait_lat4(8);
    check_frame4(0, BLANK4, 1'b1);
    check_frame4(4, {16'hFE66, 16'hFDF2, 16'hFBDA, 16'hF760}, 1'b1);
    check("upd_after_first", 32'(nupd4), 32'd1);

    // Two loads inside frame 3: only the last is shown, one updated pulse
    wait_lat4(9);
    do_load(16'h1111, 32'h0, 4'h0, 4'h0, 1'b0);
    repeat (10) @(negedge clk);
    do_load(16'hABCD, 32'h0, 4'h0, 4'h0, 1'b0);
    wait_lat4(16);
    check_frame4(8, {16'hFE66, 16'hFDF2, 16'hFBDA, 16'hF760}, 1'b0);
    check_frame4(12, {16'hFE7A, 16'hFD9C, 16'hFB3E, 16'hF7EE}, 1'b0);
    check("upd_double_load", 32'(nupd4), 32'd2);

    // Select-byte sweep on the 8-digit and 3-digit active-high instances
    check("sel8_d6", 32'(w8[6]), 32'h0000BF00);
    check("sel8_d7", 32'(w8[7]), 32'h00007F00);
    check("idx8_d7", 32'(di8[7]), 32'd7);
    check("idx8_wrap", 32'(di8[8]), 32'd0);
    check("sel8_wrap", 32'(w8[8]), 32'h0000FE00);
    check("sel3_d0", 32'(w3[0]), 32'h00000100);
    check("sel3_d1", 32'(w3[1]), 32'h00000200);
    check("sel3_d2", 32'(w3[2]), 32'h00000400);
    check("idx3_wrap", 32'(di3[3]), 32'd0);
    check("sel3_wrap", 32'(w3[3]), 32'h00000100);

    // Raw mode (blank still overrides raw), then hex with decimal point and a blanked digit
    wait_lat4(17);
    do_load(16'hFFFF, {8'h56, 8'h81, 8'h34, 8'h12}, 4'hF, 4'b1000, 1'b1);
    wait_lat4(25);
    do_load(16'h7A85, 32'h0, 4'b0010, 4'b0100, 1'b0);
    wait_lat4(32);
    check_frame4(20, {16'hFE12, 16'hFD34, 16'hFB81, 16'hF700}, 1'b0);
    check_frame4(28, {16'hFEB6, 16'hFDFF, 16'hFB00, 16'hF7E0}, 1'b0);
    check("upd_modes", 32'(nupd4), 32'd4);

    // Reset while bit 9 of digit 1 is on sdata; a load is pending and must be dropped
    wait_lat4(33);
    base = sck4;
    do_load(16'h1234, 32'h0, 4'h0, 4'h0, 1'b0);
    k = 0;
    while (sck4 < base + 6 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("bit10_reached", 32'(sck4 - base), 32'd6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bit9_sclk", 32'(sclk4), 32'd0);
    check("bit9_sdata", 32'(sdata4), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sclk", 32'(sclk4), 32'd0);
    check("midrst_rclk", 32'(rclk4), 32'd0);
    check("midrst_srclr", 32'(srclr4), 32'd0);
    check("midrst_idx", 32'(didx4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cur = n4;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("reclear_low_%0d", i), 32'(srclr4), 32'd0);
    end
    @(negedge clk);
    check("reclear_done", 32'(srclr4), 32'd1);
    wait_lat4(cur + 8);
    check_frame4(cur, BLANK4, 1'b0);
    check_frame4(cur + 4, BLANK4, 1'b1);
    check("upd_after_midrst", 32'(nupd4), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
